// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C register slave: FSM encoding and SDA drive levels.
package i2c_slave_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX_BYTE  = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX_BYTE  = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RELEASE = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and derives edge pulses plus START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic nrst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta_reg, scl_sync_reg, scl_prev_reg;
    logic sda_meta_reg, sda_sync_reg, sda_prev_reg;
    logic sda_rise, sda_fall;

    // Two-flop synchroniser plus a history flop per line; idle bus level is high.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            scl_meta_reg <= 1'b1;
            scl_sync_reg <= 1'b1;
            scl_prev_reg <= 1'b1;
            sda_meta_reg <= 1'b1;
            sda_sync_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_meta_reg <= scl_in;
            scl_sync_reg <= scl_meta_reg;
            scl_prev_reg <= scl_sync_reg;
            sda_meta_reg <= sda_in;
            sda_sync_reg <= sda_meta_reg;
            sda_prev_reg <= sda_sync_reg;
        end
    end

    assign sda       = sda_sync_reg;
    assign scl_rise  = scl_sync_reg & ~scl_prev_reg;
    assign scl_fall  = ~scl_sync_reg & scl_prev_reg;
    assign sda_rise  = sda_sync_reg & ~sda_prev_reg;
    assign sda_fall  = ~sda_sync_reg & sda_prev_reg;
    // SDA moving while SCL is high is a bus condition, never data.
    assign start_det = sda_fall & scl_sync_reg;
    assign stop_det  = sda_rise & scl_sync_reg;

endmodule

// File: rtl/i2c_slave_responder.sv
// Register-file I2C slave: address match/ACK, pointer-then-data writes, auto-increment reads.
module i2c_slave_responder
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_COUNT  = 4,
    parameter int         PTR_W      = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i2c_scl_i,
    input  logic             i2c_sda_i,
    output logic             i2c_slave_sda_o,
    input  logic [PTR_W-1:0] reg_rd_addr,
    output logic [7:0]       reg_rd_data,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_index,
    output logic             busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .nrst      (nrst),
        .scl_in    (i2c_scl_i),
        .sda_in    (i2c_sda_i),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t           state_reg, state_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             sda_reg, sda_next;
    logic             busy_reg, busy_next;
    logic [PTR_W-1:0] pointer_reg, pointer_next;
    logic             rw_reg, rw_next;
    logic             first_reg, first_next;
    logic             ack_seen_reg, ack_seen_next;
    logic             wr_strobe_reg, wr_strobe_next;
    logic [PTR_W-1:0] wr_index_reg, wr_index_next;

    logic [7:0]           regs [REG_COUNT];
    logic [7:0]           byte_in;
    logic [7:0]           tx_word;
    logic                 reg_we;
    logic [REG_COUNT-1:0] reg_sel;

    assign byte_in = {shift_reg[6:0], sda_s};
    assign tx_word = regs[pointer_reg];

    // State and datapath registers; reset releases SDA on the same edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            sda_reg       <= RELEASE;
            busy_reg      <= 1'b0;
            pointer_reg   <= '0;
            rw_reg        <= 1'b0;
            first_reg     <= 1'b0;
            ack_seen_reg  <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_index_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            sda_reg       <= sda_next;
            busy_reg      <= busy_next;
            pointer_reg   <= pointer_next;
            rw_reg        <= rw_next;
            first_reg     <= first_next;
            ack_seen_reg  <= ack_seen_next;
            wr_strobe_reg <= wr_strobe_next;
            wr_index_reg  <= wr_index_next;
        end
    end

    // Next-state logic; START/STOP override whatever byte is in flight.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        sda_next       = sda_reg;
        busy_next      = busy_reg;
        pointer_next   = pointer_reg;
        rw_next        = rw_reg;
        first_next     = first_reg;
        ack_seen_next  = ack_seen_reg;
        wr_strobe_next = 1'b0;
        wr_index_next  = wr_index_reg;
        reg_we         = 1'b0;

        if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            sda_next     = RELEASE;
            busy_next    = 1'b0;
        end else if (stop_det) begin
            state_next = ST_IDLE;
            sda_next   = RELEASE;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rw_next = byte_in[0];
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_next = ST_ADDR_ACK;
                                busy_next  = 1'b1;
                            end else begin
                                state_next = ST_IGNORE;
                            end
                        end
                    end
                end
                // First fall starts the ACK; second fall ends it and picks the direction.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = '0;
                        if (sda_reg == RELEASE) begin
                            sda_next = ACK;
                        end else if (!rw_reg) begin
                            sda_next   = RELEASE;
                            first_next = 1'b1;
                            state_next = ST_RX_BYTE;
                        end else begin
                            sda_next   = tx_word[7];
                            shift_next = tx_word;
                            state_next = ST_TX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_next = ST_RX_ACK;
                            if (first_reg) begin
                                pointer_next = byte_in[PTR_W-1:0];
                                first_next   = 1'b0;
                            end else begin
                                reg_we         = 1'b1;
                                wr_strobe_next = 1'b1;
                                wr_index_next  = pointer_reg;
                                pointer_next   = pointer_reg + PTR_W'(1);
                            end
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (sda_reg == RELEASE) begin
                            sda_next = ACK;
                        end else begin
                            sda_next     = RELEASE;
                            bit_cnt_next = '0;
                            state_next   = ST_RX_BYTE;
                        end
                    end
                end
                // Bit 7 is already on the wire on entry; each fall presents the next bit.
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 3'd7) begin
                            sda_next      = RELEASE;
                            pointer_next  = pointer_reg + PTR_W'(1);
                            ack_seen_next = 1'b0;
                            state_next    = ST_TX_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                            sda_next     = shift_reg[3'd6 - bit_cnt_reg];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == ACK) begin
                            ack_seen_next = 1'b1;
                        end else begin
                            state_next = ST_IGNORE;
                            busy_next  = 1'b0;
                        end
                    end else if (scl_fall && ack_seen_reg) begin
                        sda_next     = tx_word[7];
                        shift_next   = tx_word;
                        bit_cnt_next = '0;
                        state_next   = ST_TX_BYTE;
                    end
                end
                default: begin
                    sda_next = RELEASE;
                end
            endcase
        end
    end

    // One select line per register so only the addressed entry loads.
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_sel
            assign reg_sel[gi] = reg_we && (pointer_reg == PTR_W'(gi));
        end
    endgenerate

    // Register file; cleared by reset, written when a data byte completes.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (reg_sel[i]) regs[i] <= byte_in;
            end
        end
    end

    assign reg_rd_data     = regs[reg_rd_addr];
    assign i2c_slave_sda_o = sda_reg;
    assign busy            = busy_reg;
    assign wr_strobe       = wr_strobe_reg;
    assign wr_index        = wr_index_reg;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bit-banged I2C master driving the slave over a wired-AND bus, with write/read scoreboards.
module tb_i2c_slave_responder;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [1:0] reg_rd_addr = 2'd0;
    logic       i2c_scl, i2c_sda, i2c_slave_sda_o;
    logic [7:0] reg_rd_data;
    logic       wr_strobe, busy;
    logic [1:0] wr_index;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         strobe_count = 0;
    bit         sda_low_seen = 0;
    logic [7:0] model [4];
    logic [1:0] wr_exp_q [$];
    logic [7:0] rd_exp_q [$];

    always #5 clk = ~clk;

    assign i2c_scl = m_scl;
    assign i2c_sda = m_sda & i2c_slave_sda_o;

    i2c_slave_responder #(.SLAVE_ADDR(7'h50), .REG_COUNT(4), .PTR_W(2)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .i2c_scl_i       (i2c_scl),
        .i2c_sda_i       (i2c_sda),
        .i2c_slave_sda_o (i2c_slave_sda_o),
        .reg_rd_addr     (reg_rd_addr),
        .reg_rd_data     (reg_rd_data),
        .wr_strobe       (wr_strobe),
        .wr_index        (wr_index),
        .busy            (busy)
    );

    // Write scoreboard: every strobe must match the next expected index.
    always @(negedge clk) begin
        logic [1:0] exp_idx;
        if (i2c_slave_sda_o === 1'b0) sda_low_seen = 1;
        if (nrst && wr_strobe === 1'b1) begin
            strobe_count++;
            tests_run++;
            if (wr_exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_strobe_unexpected: wr_index=%0d, required no strobe", wr_index);
            end else begin
                exp_idx = wr_exp_q.pop_front();
                if (wr_index !== exp_idx) begin
                    tests_failed++;
                    $display("FAIL wr_index: got %0d, required %0d", wr_index, exp_idx);
                end else begin
                    $display("[TB] wr_strobe wr_index=%0d", wr_index);
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1; wait_q();
            m_scl = 1'b1; wait_q();
        end
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
        $display("[TB] START");
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
        $display("[TB] STOP");
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        ack = (i2c_sda == 1'b0);
        wait_q();
        m_scl = 1'b0; wait_q();
        $display("[TB] wr byte 0x%02h ack=%0d", b, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            m_scl = 1'b1; wait_q();
            d[i] = i2c_sda;
            wait_q();
            m_scl = 1'b0;
        end
        wait_q();
        m_sda = nack; wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0;
        repeat (2) @(negedge clk);
        m_sda = 1'b1; wait_q();
        $display("[TB] rd byte 0x%02h nack=%0d", d, nack);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run += 4;
        if (i2c_slave_sda_o !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b, required 1", i2c_slave_sda_o); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (wr_strobe !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_strobe: got %b, required 0", wr_strobe); end
        if (wr_index !== 2'd0) begin tests_failed++; $display("FAIL reset_wr_index: got %0d, required 0", wr_index); end
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            reg_rd_addr = 2'(i); #1;
            tests_run++;
            if (reg_rd_data !== model[i]) begin tests_failed++; $display("FAIL reset_reg%0d: got 0x%02h, required 0x%02h", i, reg_rd_data, model[i]); end
        end
    endtask

    task automatic test_idle();
        sda_low_seen = 0;
        repeat (200) @(negedge clk);
        tests_run += 2;
        if (sda_low_seen) begin tests_failed++; $display("FAIL idle_sda: got driven low, required released"); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_write_seq(input string name, input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] bytes [4];
        logic ack;
        logic [1:0] p;
        bytes[0] = 8'hA0; bytes[1] = ptr; bytes[2] = d0; bytes[3] = d1;
        p = ptr[1:0];
        strobe_count = 0;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) begin
                wr_exp_q.push_back(p);
                model[p] = bytes[i];
                p = p + 2'd1;
            end
            write_byte(bytes[i], ack);
            tests_run++;
            if (ack !== 1'b1) begin tests_failed++; $display("FAIL %s_ack%0d: got nack, required ack", name, i); end
        end
        i2c_stop();
        repeat (10) @(negedge clk);
        tests_run += 3;
        if (strobe_count != 2) begin tests_failed++; $display("FAIL %s_strobes: got %0d, required 2", name, strobe_count); end
        if (wr_exp_q.size() != 0) begin tests_failed++; $display("FAIL %s_missing_strobe: got %0d pending, required 0", name, wr_exp_q.size()); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL %s_busy: got %b, required 0", name, busy); end
        for (int i = 0; i < 4; i++) begin
            reg_rd_addr = 2'(i); #1;
            tests_run++;
            if (reg_rd_data !== model[i]) begin tests_failed++; $display("FAIL %s_reg%0d: got 0x%02h, required 0x%02h", name, i, reg_rd_data, model[i]); end
        end
    endtask

    task automatic test_random_read();
        logic ack;
        logic [7:0] d, exp_d;
        i2c_start();
        write_byte(8'hA0, ack);
        tests_run++;
        if (ack !== 1'b1) begin tests_failed++; $display("FAIL read_addr_w_ack: got nack, required ack"); end
        write_byte(8'h02, ack);
        tests_run++;
        if (ack !== 1'b1) begin tests_failed++; $display("FAIL read_ptr_ack: got nack, required ack"); end
        i2c_start();
        write_byte(8'hA1, ack);
        tests_run += 2;
        if (ack !== 1'b1) begin tests_failed++; $display("FAIL read_addr_r_ack: got nack, required ack"); end
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL read_busy_high: got %b, required 1", busy); end
        for (int i = 0; i < 2; i++) begin
            rd_exp_q.push_back(model[2 + i]);
            read_byte(i == 1, d);
            exp_d = rd_exp_q.pop_front();
            tests_run++;
            if (d !== exp_d) begin tests_failed++; $display("FAIL read_data%0d: got 0x%02h, required 0x%02h", i, d, exp_d); end
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL read_busy_after_nack: got %b, required 0", busy); end
        i2c_stop();
    endtask

    task automatic test_mismatch();
        logic ack;
        strobe_count = 0;
        sda_low_seen = 0;
        i2c_start();
        write_byte(8'hA2, ack);
        tests_run++;
        if (ack !== 1'b0) begin tests_failed++; $display("FAIL mismatch_addr_ack: got ack, required nack"); end
        write_byte(8'h11, ack);
        tests_run++;
        if (ack !== 1'b0) begin tests_failed++; $display("FAIL mismatch_data_ack: got ack, required nack"); end
        i2c_stop();
        repeat (10) @(negedge clk);
        tests_run += 3;
        if (sda_low_seen) begin tests_failed++; $display("FAIL mismatch_sda: got driven low, required released"); end
        if (strobe_count != 0) begin tests_failed++; $display("FAIL mismatch_strobes: got %0d, required 0", strobe_count); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL mismatch_busy: got %b, required 0", busy); end
        for (int i = 0; i < 4; i++) begin
            reg_rd_addr = 2'(i); #1;
            tests_run++;
            if (reg_rd_data !== model[i]) begin tests_failed++; $display("FAIL mismatch_reg%0d: got 0x%02h, required 0x%02h", i, reg_rd_data, model[i]); end
        end
    endtask

    task automatic test_abort();
        logic ack;
        strobe_count = 0;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h01, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_before: got %b, required 1", busy); end
        i2c_stop();
        repeat (10) @(negedge clk);
        tests_run += 2;
        if (strobe_count != 0) begin tests_failed++; $display("FAIL abort_strobes: got %0d, required 0", strobe_count); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy_after: got %b, required 0", busy); end
        for (int i = 0; i < 4; i++) begin
            reg_rd_addr = 2'(i); #1;
            tests_run++;
            if (reg_rd_data !== model[i]) begin tests_failed++; $display("FAIL abort_reg%0d: got 0x%02h, required 0x%02h", i, reg_rd_data, model[i]); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        // reg[0] holds 0x22, so the slave is now driving bit 7 = 0.
        tests_run++;
        if (i2c_slave_sda_o !== 1'b0) begin tests_failed++; $display("FAIL midread_driving: got %b, required 0", i2c_slave_sda_o); end
        nrst = 1'b0;
        @(posedge clk); #1;
        tests_run += 2;
        if (i2c_slave_sda_o !== 1'b1) begin tests_failed++; $display("FAIL midread_sda_release: got %b, required 1", i2c_slave_sda_o); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midread_busy: got %b, required 0", busy); end
        @(negedge clk);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            reg_rd_addr = 2'(i); #1;
            tests_run++;
            if (reg_rd_data !== model[i]) begin tests_failed++; $display("FAIL midread_reg%0d: got 0x%02h, required 0x%02h", i, reg_rd_data, model[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write_seq("write", 8'h02, 8'h5A, 8'hC3);
        test_random_read();
        test_mismatch();
        test_write_seq("wrap", 8'h03, 8'h11, 8'h22);
        test_abort();
        test_reset_mid_read();
        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
